// File: rtl/mux_2to1_rr_arb.sv
// Registered 2:1 round-robin stream arbiter.
// Two valid/ready sources (a, b) compete for one output register. A one-bit
// last-winner pointer breaks ties so that sources alternate under contention.
// The winning word is held in a one-entry output register and is tagged with
// y_sel (0 = a, 1 = b), the same encoding a 2:1 gate mux consumes.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   a        in   source A data          a_valid in / a_ready out
//   b        in   source B data          b_valid in / b_ready out
//   y        out  registered output data y_valid out / y_ready in
//   y_sel    out  source of y, registered with y
module mux_2to1_rr_arb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_sel
);

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StHoldA = 2'b01,
    StHoldB = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q;
  logic             y_sel_q;
  logic             last_sel_q;

  logic space;
  logic grant_a;
  logic grant_b;
  logic load;

  // Grant and handshake logic. Readies are masked during reset so that a
  // source never believes a word was taken in a cycle that reset discards.
  always_comb begin
    space   = (state_q == StEmpty) || y_ready;
    grant_b = b_valid && (!a_valid || !last_sel_q);
    grant_a = a_valid && !grant_b;
    a_ready = !reset && space && grant_a;
    b_ready = !reset && space && grant_b;
    load    = a_ready || b_ready;
  end

  // Next-state logic. A load takes priority over a drain so that a drain and
  // a load in the same cycle keep the register full with no bubble.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = grant_b ? StHoldB : StHoldA;
    end else if ((state_q != StEmpty) && y_ready) begin
      state_d = StEmpty;
    end
  end

  // State and datapath registers. last_sel resets to 1 so A wins the first tie.
  // y and y_sel are only written on a load; a drain leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      y_q        <= '0;
      y_sel_q    <= 1'b0;
      last_sel_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (load) begin
        y_q        <= grant_b ? b : a;
        y_sel_q    <= grant_b;
        last_sel_q <= grant_b;
      end
    end
  end

  // Output decode.
  always_comb begin
    y_valid = (state_q != StEmpty);
    y       = y_q;
    y_sel   = y_sel_q;
  end

endmodule

// File: tb/tb_mux_2to1_rr_arb.sv
module tb_mux_2to1_rr_arb;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             y_sel;

  mux_2to1_rr_arb #(
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_sel   (y_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: output-register occupancy and round-robin pointer.
  logic m_yv;
  logic m_last;
  logic m_space, m_ga, m_gb;
  logic e_ar, e_br;
  // Values seen at the most recent sample point.
  logic s_ar, s_br, s_av, s_bv;

  // Scoreboard entries are {sel, data} of words accepted from a source.
  logic [WIDTH:0] sb_q[$];

  // One clock cycle: sample/compare on the falling edge, advance the model on
  // the rising edge, return 1 time unit later so callers may drive inputs.
  task automatic sb_cycle(input string tag);
    logic [WIDTH:0] popped;
    @(negedge clk);
    m_space = !m_yv || y_ready;
    m_gb    = b_valid && (!a_valid || !m_last);
    m_ga    = a_valid && !m_gb;
    e_ar    = !reset && m_space && m_ga;
    e_br    = !reset && m_space && m_gb;
    s_ar = a_ready; s_br = b_ready; s_av = a_valid; s_bv = b_valid;
    n_cmp++;
    if (a_ready !== e_ar) begin
      n_err++;
      $display("FAIL %s a_ready: got %b expected %b at %0t", tag, a_ready, e_ar, $time);
    end
    n_cmp++;
    if (b_ready !== e_br) begin
      n_err++;
      $display("FAIL %s b_ready: got %b expected %b at %0t", tag, b_ready, e_br, $time);
    end
    n_cmp++;
    if (y_valid !== m_yv) begin
      n_err++;
      $display("FAIL %s y_valid: got %b expected %b at %0t", tag, y_valid, m_yv, $time);
    end
    if (m_yv) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL %s scoreboard: got y=%h sel=%b expected no word at %0t",
                 tag, y, y_sel, $time);
      end else if ({y_sel, y} !== sb_q[0]) begin
        n_err++;
        $display("FAIL %s y/y_sel: got sel=%b y=%h expected sel=%b y=%h at %0t",
                 tag, y_sel, y, sb_q[0][WIDTH], sb_q[0][WIDTH-1:0], $time);
      end
    end
    @(posedge clk);
    if (reset) begin
      m_yv   = 1'b0;
      m_last = 1'b1;
      sb_q.delete();
    end else begin
      if (m_yv && y_ready && sb_q.size() > 0) popped = sb_q.pop_front();
      if (e_ar || e_br) begin
        sb_q.push_back({e_br, e_br ? b : a});
        m_yv   = 1'b1;
        m_last = e_br;
      end else if (m_yv && y_ready) begin
        m_yv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    a = 8'hAA; b = 8'hBB;
    for (int i = 0; i < 2; i++) begin
      sb_cycle("reset");
      n_cmp++;
      if ({y_valid, y_sel, y} !== {1'b0, 1'b0, 8'h00}) begin
        n_err++;
        $display("FAIL reset_state: got v=%b sel=%b y=%h expected v=0 sel=0 y=00",
                 y_valid, y_sel, y);
      end
      n_cmp++;
      if ({a_ready, b_ready} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_ready: got %b%b expected 00", a_ready, b_ready);
      end
    end
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_tie();
    logic [WIDTH-1:0] exp_y[4];
    exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h11; exp_y[3] = 8'h22;
    a = 8'h11; b = 8'h22; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_cycle("tie");
      n_cmp++;
      if ({y_valid, y_sel, y} !== {1'b1, i[0], exp_y[i]}) begin
        n_err++;
        $display("FAIL tie_seq[%0d]: got v=%b sel=%b y=%h expected v=1 sel=%b y=%h",
                 i, y_valid, y_sel, y, i[0], exp_y[i]);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    sb_cycle("tie_drain");
  endtask

  task automatic test_a_alone();
    a = 8'h5A; a_valid = 1'b1; b_valid = 1'b0; y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_cycle("a_alone");
      n_cmp++;
      if ({y_valid, y_sel, y} !== {1'b1, 1'b0, 8'h5A}) begin
        n_err++;
        $display("FAIL a_alone: got v=%b sel=%b y=%h expected v=1 sel=0 y=5a",
                 y_valid, y_sel, y);
      end
    end
    a_valid = 1'b0;
    sb_cycle("a_alone_drain");
  endtask

  task automatic test_backpressure();
    b = 8'h22; b_valid = 1'b1; a_valid = 1'b0; y_ready = 1'b1;
    sb_cycle("bp_load");
    a = 8'h33; a_valid = 1'b1; y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_cycle("bp_stall");
      n_cmp++;
      if ({y_valid, y_sel, y, a_ready, b_ready} !== {1'b1, 1'b1, 8'h22, 2'b00}) begin
        n_err++;
        $display("FAIL bp_stall: got v=%b sel=%b y=%h rdy=%b%b expected v=1 sel=1 y=22 rdy=00",
                 y_valid, y_sel, y, a_ready, b_ready);
      end
    end
    y_ready = 1'b1;
    sb_cycle("bp_release");
    n_cmp++;
    if ({y_valid, y_sel, y} !== {1'b1, 1'b0, 8'h33}) begin
      n_err++;
      $display("FAIL bp_release: got v=%b sel=%b y=%h expected v=1 sel=0 y=33",
               y_valid, y_sel, y);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    sb_cycle("bp_drain");
  endtask

  task automatic test_reset_midstream();
    // Load from A so the pointer would favour B on the next tie without reset.
    a = 8'h44; a_valid = 1'b1; b_valid = 1'b0; y_ready = 1'b1;
    sb_cycle("mid_load");
    y_ready = 1'b0; reset = 1'b1;
    sb_cycle("mid_reset");
    n_cmp++;
    if ({y_valid, y_sel, y} !== {1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b sel=%b y=%h expected v=0 sel=0 y=00",
               y_valid, y_sel, y);
    end
    reset = 1'b0; a = 8'h55; b = 8'h66; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    sb_cycle("mid_tie");
    n_cmp++;
    if ({y_valid, y_sel, y} !== {1'b1, 1'b0, 8'h55}) begin
      n_err++;
      $display("FAIL mid_first_tie: got v=%b sel=%b y=%h expected v=1 sel=0 y=55",
               y_valid, y_sel, y);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    sb_cycle("mid_drain");
  endtask

  task automatic test_random();
    logic [6:0] a_cnt, b_cnt;
    int         a_wait, b_wait;
    a_cnt = '0; b_cnt = '0; a_wait = 0; b_wait = 0;
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      a = {1'b0, a_cnt};
      b = {1'b1, b_cnt};
      y_ready = ($urandom_range(3) != 0);
      sb_cycle("random");
      // Per-source waiting: count grants to the other side while valid.
      if (s_ar) a_wait = 0; else if (s_av && s_br) a_wait++;
      if (s_br) b_wait = 0; else if (s_bv && s_ar) b_wait++;
      n_cmp++;
      if (a_wait > 1 || b_wait > 1) begin
        n_err++;
        $display("FAIL fairness: got a_wait=%0d b_wait=%0d expected <=1 at %0t",
                 a_wait, b_wait, $time);
      end
      // Valid is held until accepted; data advances only on acceptance.
      if (e_ar) begin a_cnt++; a_valid = $urandom_range(1); end
      else if (!a_valid) a_valid = $urandom_range(1);
      if (e_br) begin b_cnt++; b_valid = $urandom_range(1); end
      else if (!b_valid) b_valid = $urandom_range(1);
    end
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    sb_cycle("random_drain");
    sb_cycle("random_drain");
    n_cmp++;
    if (sb_q.size() != 0 || y_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_leftover: got %0d queued, y_valid=%b expected 0 queued, y_valid=0",
               sb_q.size(), y_valid);
    end
  endtask

  initial begin
    reset = 1'b1; a = '0; b = '0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    m_yv = 1'b0; m_last = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_tie();
    test_a_alone();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
